// File: rtl/dircc_receive_sequencer.sv
// dircc_receive_sequencer
//   Buffers network packets, fetches the device state for each one, presents
//   the packet and state to the receive handler, and writes the handler's
//   updated state back. A written-back state with STOP_BIT set latches
//   `stopped`. After that, buffered packets are discarded and counted.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   rx_data/valid/ready network-side packet input (rx_ready = !full)
//   state_read_*        state memory read (req held until valid pulse)
//   packet_in*, read_state, receive_done
//                       handler presentation; receive_done is a 1-cycle strobe
//   packet_handled, write_state, write_state_valid
//                       handler completion and updated state
//   state_write*, state_write_ack
//                       state memory write (req held until ack)
//   stopped, timeout_err, drop_count
//                       sticky status flags and discarded-packet counter
module dircc_receive_sequencer #(
  parameter int unsigned PACKET_DATA_WIDTH = 32,
  parameter int unsigned STATE_WIDTH       = 64,
  parameter int unsigned STOP_BIT          = 1,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned HANDLE_TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PACKET_DATA_WIDTH-1:0] rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic                         state_read_req,
  input  logic [STATE_WIDTH-1:0]       state_read_data,
  input  logic                         state_read_valid,
  output logic [PACKET_DATA_WIDTH-1:0] packet_in,
  output logic                         packet_in_valid,
  output logic [STATE_WIDTH-1:0]       read_state,
  output logic                         receive_done,
  input  logic                         packet_handled,
  input  logic [STATE_WIDTH-1:0]       write_state,
  input  logic                         write_state_valid,
  output logic                         state_write,
  output logic [STATE_WIDTH-1:0]       state_write_data,
  input  logic                         state_write_ack,
  output logic                         stopped,
  output logic                         timeout_err,
  output logic [15:0]                  drop_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(HANDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DISPATCH  = 3'd2,
    ST_WAIT      = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;

  state_t                       state;
  logic [PACKET_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             fifo_cnt;
  logic [CNT_W-1:0]             cnt_next;
  logic                         fifo_empty;
  logic                         push;
  logic                         pop;
  logic [TMO_W-1:0]             tmo_cnt;
  logic [STATE_WIDTH-1:0]       wb_state;
  logic                         have_state;

  // FIFO handshake: the head leaves only on an IDLE cycle (dispatch or drop)
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = rx_valid && rx_ready;
  assign pop        = (state == ST_IDLE) && !fifo_empty;

  // Occupancy after this edge; a simultaneous push and pop cancel
  always_comb begin
    cnt_next = fifo_cnt;
    if (push && !pop) begin
      cnt_next = fifo_cnt + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_next = fifo_cnt - CNT_W'(1);
    end
  end

  // Packet storage: data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= rx_data;
    end
  end

  // FIFO bookkeeping and sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
      rx_ready         <= 1'b0;
      state_read_req   <= 1'b0;
      packet_in        <= '0;
      packet_in_valid  <= 1'b0;
      read_state       <= '0;
      receive_done     <= 1'b0;
      state_write      <= 1'b0;
      state_write_data <= '0;
      stopped          <= 1'b0;
      timeout_err      <= 1'b0;
      drop_count       <= '0;
      tmo_cnt          <= '0;
      wb_state         <= '0;
      have_state       <= 1'b0;
    end else begin
      // Pointers wrap naturally since FIFO_DEPTH is a power of two
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_cnt     <= cnt_next;
      rx_ready     <= (cnt_next != CNT_W'(FIFO_DEPTH));
      receive_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (stopped) begin
              // Discard one packet per cycle once the device is stopped
              if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
              end
            end else begin
              packet_in      <= fifo_mem[rd_ptr];
              state_read_req <= 1'b1;
              state          <= ST_FETCH;
            end
          end
        end

        ST_FETCH: begin
          if (state_read_valid) begin
            read_state      <= state_read_data;
            state_read_req  <= 1'b0;
            receive_done    <= 1'b1;
            packet_in_valid <= 1'b1;
            state           <= ST_DISPATCH;
          end
        end

        ST_DISPATCH: begin
          tmo_cnt    <= '0;
          have_state <= 1'b0;
          state      <= ST_WAIT;
        end

        ST_WAIT: begin
          if (write_state_valid) begin
            wb_state   <= write_state;
            have_state <= 1'b1;
          end
          if (packet_handled) begin
            packet_in_valid <= 1'b0;
            if (write_state_valid || have_state) begin
              // Same-cycle write_state beats an earlier capture
              state_write      <= 1'b1;
              state_write_data <= write_state_valid ? write_state : wb_state;
              state            <= ST_WRITEBACK;
            end else begin
              state <= ST_IDLE;
            end
          end else if (tmo_cnt == TMO_W'(HANDLE_TIMEOUT - 1)) begin
            // This is the HANDLE_TIMEOUT-th WAIT cycle without completion
            timeout_err     <= 1'b1;
            packet_in_valid <= 1'b0;
            state           <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_WRITEBACK: begin
          if (state_write_ack) begin
            state_write <= 1'b0;
            if (state_write_data[STOP_BIT]) begin
              stopped <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dircc_receive_sequencer.sv
// Directed bench for dircc_receive_sequencer: single packet, FIFO full and
// ordering, handled-without-state, timeout, stop/drop, reset mid-FETCH.
module tb_dircc_receive_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        state_read_req;
  logic [63:0] state_read_data;
  logic        state_read_valid;
  logic [31:0] packet_in;
  logic        packet_in_valid;
  logic [63:0] read_state;
  logic        receive_done;
  logic        packet_handled;
  logic [63:0] write_state;
  logic        write_state_valid;
  logic        state_write;
  logic [63:0] state_write_data;
  logic        state_write_ack;
  logic        stopped;
  logic        timeout_err;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  // Memory model controls and observation counters
  logic        mem_en;
  logic [63:0] mem_state;
  int          mem_age;
  int          wr_cnt   = 0;
  logic [63:0] wr_last  = '0;
  int          done_cnt = 0;
  int          req_cyc  = 0;

  int w0;
  int r0;
  int d0;

  always #5 clk = ~clk;

  dircc_receive_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .state_read_req    (state_read_req),
    .state_read_data   (state_read_data),
    .state_read_valid  (state_read_valid),
    .packet_in         (packet_in),
    .packet_in_valid   (packet_in_valid),
    .read_state        (read_state),
    .receive_done      (receive_done),
    .packet_handled    (packet_handled),
    .write_state       (write_state),
    .write_state_valid (write_state_valid),
    .state_write       (state_write),
    .state_write_data  (state_write_data),
    .state_write_ack   (state_write_ack),
    .stopped           (stopped),
    .timeout_err       (timeout_err),
    .drop_count        (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the receive_done strobe, sampling on negedges
  task automatic wait_done();
    int n;
    n = 0;
    while (receive_done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(receive_done), 64'd1);
  endtask

  task automatic push(input logic [31:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Read memory answers one cycle after seeing the request; write is acked at once
  initial begin
    state_read_valid = 1'b0;
    state_read_data  = '0;
    state_write_ack  = 1'b0;
    mem_age          = 0;
    forever begin
      @(negedge clk);
      state_read_valid = 1'b0;
      state_write_ack  = 1'b0;
      if (mem_en && state_read_req) mem_age++;
      else mem_age = 0;
      if (mem_age == 2) begin
        state_read_valid = 1'b1;
        state_read_data  = mem_state;
        mem_age          = 0;
      end
      if (state_write) begin
        state_write_ack = 1'b1;
        wr_cnt++;
        wr_last = state_write_data;
      end
      if (receive_done) done_cnt++;
      if (state_read_req) req_cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; packet_handled = 1'b0;
    write_state = '0; write_state_valid = 1'b0; mem_en = 1'b0; mem_state = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(rx_ready), 64'd0);
    chk("rst_req",   64'(state_read_req), 64'd0);
    chk("rst_piv",   64'(packet_in_valid), 64'd0);
    chk("rst_stop",  64'(stopped), 64'd0);
    chk("rst_tmo",   64'(timeout_err), 64'd0);
    chk("rst_drop",  64'(drop_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(rx_ready), 64'd1);

    // Single packet with minimum latency
    mem_en = 1'b1; mem_state = 64'h0000_0000_0003_0007;
    push(32'h5);
    chk("t1_req_n",  64'(state_read_req), 64'd0);
    @(negedge clk); chk("t1_req_n1", 64'(state_read_req), 64'd1);
    @(negedge clk); chk("t1_done_n2", 64'(receive_done), 64'd0);
    @(negedge clk);
    chk("t1_done_n3", 64'(receive_done), 64'd1);
    chk("t1_pkt",     64'(packet_in), 64'h5);
    chk("t1_rstate",  read_state, 64'h0000_0000_0003_0007);
    chk("t1_piv",     64'(packet_in_valid), 64'd1);
    w0 = wr_cnt;
    @(negedge clk);
    chk("t1_done_once", 64'(receive_done), 64'd0);
    chk("t1_piv_wait",  64'(packet_in_valid), 64'd1);
    write_state = 64'h8; write_state_valid = 1'b1; packet_handled = 1'b1;
    @(negedge clk);
    write_state_valid = 1'b0; packet_handled = 1'b0;
    chk("t1_sw",    64'(state_write), 64'd1);
    chk("t1_swd",   state_write_data, 64'h8);
    chk("t1_piv_wb", 64'(packet_in_valid), 64'd0);
    @(negedge clk);
    chk("t1_sw_off", 64'(state_write), 64'd0);
    chk("t1_wrcnt",  64'(wr_cnt), 64'(w0 + 1));
    chk("t1_stop",   64'(stopped), 64'd0);

    // FIFO full: one packet in FETCH, four buffered, sixth push blocked
    mem_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 32'(32'h10 + i);
      chk("t2_ready", 64'(rx_ready), 64'd1);
      @(negedge clk);
    end
    rx_data = 32'h99;
    chk("t2_full",  64'(rx_ready), 64'd0);
    chk("t2_fetch", 64'(state_read_req), 64'd1);
    @(negedge clk);
    chk("t2_still_full", 64'(rx_ready), 64'd0);
    rx_valid = 1'b0;
    mem_en = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      wait_done();
      chk("t2_order", 64'(packet_in), 64'(32'h10 + i));
      @(negedge clk); packet_handled = 1'b1;
      @(negedge clk); packet_handled = 1'b0;
      chk("t5_nowrite", 64'(state_write), 64'd0);
    end
    chk("t5_wrcnt",  64'(wr_cnt), 64'(w0));
    chk("t2_ready2", 64'(rx_ready), 64'd1);
    chk("t5_idle_piv", 64'(packet_in_valid), 64'd0);

    // Handler timeout
    push(32'h77);
    w0 = wr_cnt;
    wait_done();
    chk("t4_pkt", 64'(packet_in), 64'h77);
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 255) chk("t4_tmo_early", 64'(timeout_err), 64'd0);
      if (k == 256) begin
        chk("t4_tmo", 64'(timeout_err), 64'd1);
        chk("t4_piv", 64'(packet_in_valid), 64'd0);
      end
    end
    chk("t4_nowrite", 64'(wr_cnt), 64'(w0));

    // Next packet proceeds; last capture before handled wins and stops device
    push(32'h78);
    wait_done();
    chk("t4_next_pkt", 64'(packet_in), 64'h78);
    chk("t4_sticky",   64'(timeout_err), 64'd1);
    @(negedge clk); write_state_valid = 1'b1; write_state = 64'h4;
    @(negedge clk); write_state = 64'h6;
    @(negedge clk); write_state_valid = 1'b0; packet_handled = 1'b1; write_state = 64'h1;
    @(negedge clk); packet_handled = 1'b0;
    chk("t3_sw",  64'(state_write), 64'd1);
    chk("t3_swd", state_write_data, 64'h6);
    @(negedge clk);
    chk("t3_stop",  64'(stopped), 64'd1);
    chk("t3_wlast", wr_last, 64'h6);

    // Stopped: packets are dropped without fetching
    r0 = req_cyc; d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 32'(32'hA0 + i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_drop",   64'(drop_count), 64'd3);
    chk("t3_noreq",  64'(req_cyc), 64'(r0));
    chk("t3_nodone", 64'(done_cnt), 64'(d0));
    chk("t3_ready",  64'(rx_ready), 64'd1);

    // Reset mid-FETCH with one packet still buffered
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("t6_stop_clr", 64'(stopped), 64'd0);
    mem_en = 1'b0;
    rx_valid = 1'b1; rx_data = 32'h55;
    @(negedge clk); rx_data = 32'h56;
    @(negedge clk); rx_valid = 1'b0;
    chk("t6_req", 64'(state_read_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_req",   64'(state_read_req), 64'd0);
    chk("t6_async_ready", 64'(rx_ready), 64'd0);
    chk("t6_async_tmo",   64'(timeout_err), 64'd0);
    chk("t6_async_drop",  64'(drop_count), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("t6_ready", 64'(rx_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("t6_empty", 64'(state_read_req), 64'd0);
    mem_en = 1'b1;
    push(32'h60);
    wait_done();
    chk("t6_after", 64'(packet_in), 64'h60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dircc_receive_sequencer.md
Name: dircc_receive_sequencer

Overview:
- Sits directly upstream of the per-device receive handler.
- Buffers incoming packets from the network side and fetches the device state from state memory for each packet.
- Presents each packet and its state to the handler with a one-cycle receive_done strobe, then writes the handler's updated state back to memory.
- Latches a sticky stopped flag when the written-back state carries the STOPPED bit. After that, all further packets are discarded.

Parameters:
- PACKET_DATA_WIDTH, 32, width of packet payload.
- STATE_WIDTH, 64, width of a full device state word (dircc_state, dircc_state_extra, user_state packed).
- STOP_BIT, 1, bit index within the state word that marks the device STOPPED.
- FIFO_DEPTH, 4, packet buffer entries; power of two, at least 2.
- HANDLE_TIMEOUT, 255, maximum cycles to wait for packet_handled.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- rx_data  in  PACKET_DATA_WIDTH  incoming packet payload.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  buffer can accept a packet.
- state_read_req  out  1  request device state; held until state_read_valid.
- state_read_data  in  STATE_WIDTH  state from memory.
- state_read_valid  in  1  state_read_data valid; single-cycle pulse, latency 1 or more.
- packet_in  out  PACKET_DATA_WIDTH  packet to handler.
- packet_in_valid  out  1  packet_in and read_state valid.
- read_state  out  STATE_WIDTH  fetched state to handler.
- receive_done  out  1  one-cycle dispatch strobe.
- packet_handled  in  1  handler completion pulse.
- write_state  in  STATE_WIDTH  updated state from handler.
- write_state_valid  in  1  write_state valid.
- state_write  out  1  write request; held until state_write_ack.
- state_write_data  out  STATE_WIDTH  state to memory.
- state_write_ack  in  1  write accepted.
- stopped  out  1  sticky: device stopped.
- timeout_err  out  1  sticky: handler timed out.
- drop_count  out  16  packets discarded while stopped; saturates at 16'hFFFF.

Behaviour:
- Reset clears the following to 0: all outputs, FIFO pointers, FSM state (IDLE), timeout counter. While reset is high, rx_ready is 0. Reset mid-operation abandons any in-flight request with no writeback.
- FIFO handshake:
  - rx_ready = !full, registered with no bypass.
  - A push occurs on a cycle where rx_valid && rx_ready.
  - A pop occurs on an IDLE-exit edge.
  - A simultaneous push and pop is legal and leaves the count unchanged.
  - When full, rx_ready is 0 and a push is impossible.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- FSM states:
  - IDLE:
    - If FIFO is non-empty and stopped=1: pop, increment drop_count (saturating), stay in IDLE. This discards one packet per cycle.
    - If FIFO is non-empty and stopped=0: pop the head into a packet register, go to FETCH.
  - FETCH: state_read_req=1. When state_read_valid=1, capture state_read_data into read_state and go to DISPATCH.
  - DISPATCH: receive_done=1 and packet_in_valid=1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT:
    - packet_in_valid stays 1 and packet_in/read_state are held stable.
    - On the cycle write_state_valid=1, capture write_state. The last capture before packet_handled wins.
    - When packet_handled=1 with a captured state, go to WRITEBACK. Capture and packet_handled may occur in the same cycle; the same-cycle write_state is used.
    - When packet_handled=1 with no state captured, go to IDLE with no write.
    - If the counter reaches HANDLE_TIMEOUT, set timeout_err and go to IDLE with no write.
  - WRITEBACK:
    - state_write=1 and state_write_data is held until state_write_ack.
    - On ack: if state_write_data[STOP_BIT]=1, set stopped. Go to IDLE.
- packet_in_valid is 0 in IDLE, FETCH and WRITEBACK.
- Minimum latency:
  - Packet pushed at edge N: state_read_req is high in cycle N+1.
  - With 1-cycle read latency: receive_done in cycle N+3.
  - A new packet may leave IDLE the cycle after the ack.
- Only one packet is in flight at a time. stopped and timeout_err are cleared only by reset.

Test Plan:
- Single packet:
  - Stimulus: push 32'h5; state_read_valid one cycle after req with state 64'h0000_0000_0003_0007; handler pulses write_state_valid and packet_handled together with 64'h...0008; ack immediately.
  - Response: receive_done exactly one cycle; packet_in=5; state_write_data=...0008; stopped=0.
- FIFO full:
  - Stimulus: hold state_read_valid low; push 5 packets back-to-back.
  - Response: 1 packet popped into FETCH, 4 buffered; rx_ready=0; 6th push blocked. After release, packets dispatch in push order.
- Stop:
  - Stimulus: writeback state with bit STOP_BIT set and ack; then push 3 packets.
  - Response: stopped=1; no further state_read_req; drop_count=3; rx_ready returns to 1.
- Timeout:
  - Stimulus: dispatch a packet; never assert packet_handled.
  - Response: timeout_err=1 after 255 WAIT cycles; state_write never asserted; next packet proceeds.
- Handled without state:
  - Stimulus: packet_handled with no write_state_valid.
  - Response: no state_write; FSM returns to IDLE.
- Reset mid-FETCH:
  - Stimulus: assert reset while state_read_req=1.
  - Response: all outputs 0 asynchronously; FIFO empty; after release, IDLE with rx_ready=1.
